// File: rtl/sp_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl_if
//   Request/response bundle for sp_ram_ctrl.
//
//   Handshake: a request transfers on every rising clk edge where
//   req_valid & req_ready are both 1. The master holds req_we, req_addr,
//   req_be and req_wdata stable while req_valid is high and req_ready is low.
//   The slave raises rsp_valid for exactly one cycle per response, and
//   responses come back in request order. There is no response back-pressure.
//
//   Signals
//     req_valid  master->slave  request present
//     req_ready  slave->master  slave can accept a request this cycle
//     req_we     master->slave  1 = write, 0 = read
//     req_addr   master->slave  word address
//     req_be     master->slave  byte enables; bit i covers wdata[8i+7:8i]
//     req_wdata  master->slave  write data
//     rsp_valid  slave->master  one-cycle pulse, rsp_rdata valid
//     rsp_rdata  slave->master  response data, held while rsp_valid = 0
// ---------------------------------------------------------------------------
interface sp_ram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W/8-1:0]   req_be;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl
//   Single-port synchronous RAM with a request/response handshake, per-byte
//   write enables, a read latency of 1 or 2 cycles and a clear engine that
//   writes INIT_VALUE to every word after reset or on a clear_start pulse.
//
//   Ports
//     clk          clock, all state on the rising edge
//     rst          asynchronous, active-high reset
//     clear_start  one-cycle pulse, start a full clear (ignored while clearing)
//     init_busy    1 while the clear engine runs
//     dbg_state    current FSM state (0 = CLEAR, 1 = READY)
//     bus          request/response bundle (slave side), see sp_ram_ctrl_if
// ---------------------------------------------------------------------------
module sp_ram_ctrl #(
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH      = 8,
    parameter int                 ADDR_W     = 3,
    parameter int                 RD_LATENCY = 1,
    parameter int                 WR_RESP    = 0,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_start,
    output logic          init_busy,
    output logic [0:0]    dbg_state,
    sp_ram_ctrl_if.slave  bus
);

    localparam int               BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               clr_we;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               in_range;
    logic [ADDR_W-1:0]  rd_idx;
    logic [DATA_W-1:0]  cur_word;
    logic [DATA_W-1:0]  merged_word;
    logic               wr_en;
    logic               resp_en;
    logic [DATA_W-1:0]  resp_data;

    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        init_busy     = 1'b0;
        bus.req_ready = 1'b0;
        clr_we        = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                bus.req_ready = 1'b1;
                // A request accepted this cycle still completes at this edge;
                // the clear begins writing on the following cycle.
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign dbg_state = state_q;

    // ---------------- Request decode ----------------
    assign accept   = bus.req_valid & bus.req_ready;
    // Extra MSB keeps the compare valid when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
    // Never index past the array, even for a dropped access.
    assign rd_idx   = in_range ? bus.req_addr : '0;

    always_comb begin
        cur_word    = in_range ? mem[rd_idx] : '0;
        merged_word = cur_word;
        for (int i = 0; i < BYTES; i++) begin
            if (bus.req_be[i]) begin
                merged_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
            end
        end
    end

    assign wr_en     = accept & bus.req_we & in_range;
    assign resp_en   = accept & (~bus.req_we | (WR_RESP != 0));
    // Out-of-range accesses answer with zero; writes answer write-first.
    assign resp_data = !in_range   ? '0 :
                       bus.req_we ? merged_word : cur_word;

    // ---------------- Storage ----------------
    // No reset on the array: contents are defined only by the clear engine.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q] <= INIT_VALUE;
        end else if (wr_en) begin
            mem[rd_idx] <= merged_word;
        end
    end

    // ---------------- Response pipeline ----------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              stg_valid;
            logic [DATA_W-1:0] stg_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_valid   <= 1'b0;
                    stg_data    <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                end else begin
                    stg_valid   <= resp_en;
                    if (resp_en) stg_data <= resp_data;
                    rsp_valid_q <= stg_valid;
                    if (stg_valid) rsp_rdata_q <= stg_data;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                end else begin
                    rsp_valid_q <= resp_en;
                    if (resp_en) rsp_rdata_q <= resp_data;
                end
            end
        end
    endgenerate

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_ctrl
//   Two instances: dut_a (DEPTH 8, RD_LATENCY 1, WR_RESP 0) and
//   dut_b (DEPTH 6, RD_LATENCY 2, WR_RESP 1). A reference memory per instance
//   produces expected response data and arrival cycles, which are queued at
//   drive time and popped by a per-instance monitor.
// ---------------------------------------------------------------------------
module tb_sp_ram_ctrl;

    localparam logic [31:0] INIT_A = 32'hA5A5_0F0F;
    localparam logic [31:0] INIT_B = 32'h0000_1234;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic       busy_a, busy_b;
    logic [0:0] st_a, st_b;

    sp_ram_ctrl_if #(.DATA_W(32), .ADDR_W(3)) ifa ();
    sp_ram_ctrl_if #(.DATA_W(32), .ADDR_W(3)) ifb ();

    sp_ram_ctrl #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .RD_LATENCY(1),
                  .WR_RESP(0), .INIT_VALUE(INIT_A)) dut_a (
        .clk(clk), .rst(rst), .clear_start(clr_a), .init_busy(busy_a),
        .dbg_state(st_a), .bus(ifa)
    );

    sp_ram_ctrl #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .RD_LATENCY(2),
                  .WR_RESP(1), .INIT_VALUE(INIT_B)) dut_b (
        .clk(clk), .rst(rst), .clear_start(clr_b), .init_busy(busy_b),
        .dbg_state(st_b), .bus(ifb)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_qa[$], exp_qb[$];
    int          cyc_qa[$], cyc_qb[$];
    logic [31:0] model_a[8], model_b[8];
    logic [31:0] last_a = '0, last_b = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic ready_of(input int d);
        return (d == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    task automatic model_clear(input int d);
        for (int i = 0; i < 8; i++) begin
            if (d == 0) model_a[i] = INIT_A;
            else        model_b[i] = INIT_B;
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst) begin
            last_a = '0;
        end else if (ifa.rsp_valid) begin
            if (exp_qa.size() == 0) begin
                check("a_unexpected_rsp", 32'(ifa.rsp_valid), 32'd0);
            end else begin
                check("a_rdata", ifa.rsp_rdata, exp_qa.pop_front());
                check("a_rsp_cycle", 32'(cyc), 32'(cyc_qa.pop_front()));
            end
            last_a = ifa.rsp_rdata;
        end else begin
            check("a_rdata_hold", ifa.rsp_rdata, last_a);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_b = '0;
        end else if (ifb.rsp_valid) begin
            if (exp_qb.size() == 0) begin
                check("b_unexpected_rsp", 32'(ifb.rsp_valid), 32'd0);
            end else begin
                check("b_rdata", ifb.rsp_rdata, exp_qb.pop_front());
                check("b_rsp_cycle", 32'(cyc), 32'(cyc_qb.pop_front()));
            end
            last_b = ifb.rsp_rdata;
        end else begin
            check("b_rdata_hold", ifb.rsp_rdata, last_b);
        end
    end

    // ---------------- drivers ----------------
    task automatic set_req(input int d, input logic v, input logic we,
                           input logic [2:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic clr);
        if (d == 0) begin
            ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = addr;
            ifa.req_be = be;   ifa.req_wdata = wd; clr_a = clr;
        end else begin
            ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = addr;
            ifb.req_be = be;   ifb.req_wdata = wd; clr_b = clr;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic do_req(input int d, input logic we, input logic [2:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic clr);
        int          n;
        logic [31:0] word;
        bit          in_rng;
        set_req(d, 1'b1, we, addr, be, wd, clr);
        n = 0;
        while (!ready_of(d) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("req_ready_timeout", 32'(ready_of(d)), 32'd1);
        end else begin
            in_rng = (int'(addr) < depth_of(d));
            word   = in_rng ? ((d == 0) ? model_a[addr] : model_b[addr]) : 32'h0;
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
                if (in_rng) begin
                    if (d == 0) model_a[addr] = word;
                    else        model_b[addr] = word;
                end
                if (!in_rng) word = 32'h0;
            end
            if (!we || d == 1) begin
                if (d == 0) begin exp_qa.push_back(word); cyc_qa.push_back(cyc + lat_of(d)); end
                else        begin exp_qb.push_back(word); cyc_qb.push_back(cyc + lat_of(d)); end
            end
            if (clr) model_clear(d);
        end
        @(negedge clk);
        set_req(d, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0);
    endtask

    // Counts the cycles init_busy stays high, optionally re-pulsing
    // clear_start partway through. Starts and ends at a negedge.
    task automatic count_busy(input int d, input int repulse_at, output int n);
        n = 0;
        while (busy_of(d) && n < 100) begin
            if (d == 0) clr_a = (n == repulse_at);
            else        clr_b = (n == repulse_at);
            n++;
            @(negedge clk);
        end
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    task automatic pulse_clear(input int d);
        if (d == 0) clr_a = 1'b1; else clr_b = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    // Asserts rst just after a negedge, checks reset outputs, releases it and
    // measures the clear that follows on both instances.
    task automatic reset_cycle(input string tag);
        int na, nb;
        #1 rst = 1'b1;
        exp_qa.delete(); cyc_qa.delete();
        exp_qb.delete(); cyc_qb.delete();
        repeat (2) @(negedge clk);
        check({tag, "_busy_a"},  32'(busy_a), 32'd1);
        check({tag, "_ready_a"}, 32'(ifa.req_ready), 32'd0);
        check({tag, "_rsp_a"},   32'(ifa.rsp_valid), 32'd0);
        check({tag, "_rdata_a"}, ifa.rsp_rdata, 32'd0);
        check({tag, "_state_a"}, 32'(st_a), 32'd0);
        check({tag, "_busy_b"},  32'(busy_b), 32'd1);
        check({tag, "_ready_b"}, 32'(ifb.req_ready), 32'd0);
        check({tag, "_rsp_b"},   32'(ifb.rsp_valid), 32'd0);
        check({tag, "_rdata_b"}, ifb.rsp_rdata, 32'd0);
        #1 rst = 1'b0;
        na = 0; nb = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (!busy_a && !busy_b) break;
            @(negedge clk);
        end
        check({tag, "_clear_len_a"}, 32'(na), 32'd8);
        check({tag, "_clear_len_b"}, 32'(nb), 32'd6);
        check({tag, "_ready_after_a"}, 32'(ifa.req_ready), 32'd1);
        check({tag, "_ready_after_b"}, 32'(ifb.req_ready), 32'd1);
        model_clear(0);
        model_clear(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] rw;
        set_req(0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);

        // 1. Reset state, clear length, initial contents.
        reset_cycle("por");
        for (int i = 0; i < 8; i++) do_req(0, 1'b0, 3'(i), 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) do_req(1, 1'b0, 3'(i), 4'h0, 32'h0, 1'b0);

        // 2. Byte-enable merge, no-op write, read latency 1.
        do_req(0, 1'b1, 3'd3, 4'hF, 32'hDEAD_BEEF, 1'b0);
        do_req(0, 1'b1, 3'd3, 4'b0101, 32'h1122_3344, 1'b0);
        do_req(0, 1'b0, 3'd3, 4'h0, 32'h0, 1'b0);
        do_req(0, 1'b1, 3'd3, 4'h0, 32'hFFFF_FFFF, 1'b0);
        do_req(0, 1'b0, 3'd3, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rw = $urandom;
            do_req(0, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), rw, 1'b0);
            do_req(0, 1'b0, 3'($urandom_range(0, 7)), 4'h0, 32'h0, 1'b0);
        end

        // 3. Latency 2, write-first responses, back-to-back reads.
        do_req(1, 1'b1, 3'd0, 4'hF, 32'd10, 1'b0);
        do_req(1, 1'b1, 3'd1, 4'hF, 32'd20, 1'b0);
        do_req(1, 1'b1, 3'd2, 4'hF, 32'd30, 1'b0);
        do_req(1, 1'b1, 3'd3, 4'hF, 32'd40, 1'b0);
        for (int i = 0; i < 4; i++) do_req(1, 1'b0, 3'(i), 4'h0, 32'h0, 1'b0);

        // 4. Out-of-range addresses on the 6-word instance.
        do_req(1, 1'b1, 3'd7, 4'hF, 32'h55, 1'b0);
        do_req(1, 1'b1, 3'd6, 4'hF, 32'h66, 1'b0);
        do_req(1, 1'b0, 3'd7, 4'h0, 32'h0, 1'b0);
        do_req(1, 1'b0, 3'd6, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) do_req(1, 1'b0, 3'(i), 4'h0, 32'h0, 1'b0);

        // 5. Read together with clear_start: pre-clear data, then full clear.
        do_req(0, 1'b1, 3'd2, 4'hF, 32'h0000_00AB, 1'b0);
        do_req(0, 1'b0, 3'd2, 4'h0, 32'h0, 1'b1);
        count_busy(0, -1, n);
        check("clr_with_req_len", 32'(n), 32'd8);
        do_req(0, 1'b0, 3'd2, 4'h0, 32'h0, 1'b0);
        do_req(0, 1'b0, 3'd3, 4'h0, 32'h0, 1'b0);

        // clear_start during a clear must not restart the pointer.
        pulse_clear(0);
        count_busy(0, 3, n);
        check("clr_repulse_len", 32'(n), 32'd8);
        do_req(1, 1'b1, 3'd4, 4'b0011, 32'hCAFE_F00D, 1'b1);
        count_busy(1, -1, n);
        check("clr_b_len", 32'(n), 32'd6);
        do_req(1, 1'b0, 3'd4, 4'h0, 32'h0, 1'b0);

        // 6a. Reset three cycles into a clear.
        do_req(0, 1'b1, 3'd5, 4'hF, 32'h1234_5678, 1'b0);
        pulse_clear(0);
        repeat (2) @(negedge clk);
        check("mid_clear_busy", 32'(busy_a), 32'd1);
        reset_cycle("rst_mid_clear");
        do_req(0, 1'b0, 3'd5, 4'h0, 32'h0, 1'b0);

        // 6b. Reset with a latency-2 read in flight.
        do_req(1, 1'b1, 3'd1, 4'hF, 32'h0BAD_0BAD, 1'b0);
        do_req(1, 1'b0, 3'd1, 4'h0, 32'h0, 1'b0);
        reset_cycle("rst_mid_read");
        do_req(1, 1'b0, 3'd1, 4'h0, 32'h0, 1'b0);
        do_req(0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0);

        repeat (6) @(negedge clk);
        check("drain_a", 32'(exp_qa.size()), 32'd0);
        check("drain_b", 32'(exp_qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a wait ever runs away.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
